// File: rtl/modulo_entrada_pkg.sv
// Shared definitions for the input peripheral: FSM encoding and default timing.
package modulo_entrada_pkg;

  // Handshake states seen from the CPU side.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACK   = 2'd2,
    DONE  = 2'd3
  } estado_t;

  // 10 ms of stable level at a 50 MHz system clock.
  localparam int DEBOUNCE_CYCLES_50MHZ = 500000;

endpackage

// File: rtl/modulo_entrada_debounce_sincrono.sv
// Push-button conditioning: 2-FF synchroniser, polarity normalisation,
// level debouncer and a single-cycle pulse on each accepted press.
module debounce_sincrono #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic btn_press
);

  localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level that means "not pressed".
  localparam logic            RELEASED_RAW = BTN_ACTIVE_LOW;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("debounce_sincrono: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic             sync_meta;
  logic             sync_raw;
  logic             sync_btn;
  logic             btn_stable;
  logic [CNT_W-1:0] count;

  // After this point 1 always means pressed.
  assign sync_btn = BTN_ACTIVE_LOW ? ~sync_raw : sync_raw;

  // Two-stage synchroniser; reset parks it at the released level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= RELEASED_RAW;
      sync_raw  <= RELEASED_RAW;
    end else begin
      sync_meta <= button_in;
      sync_raw  <= sync_meta;
    end
  end

  // Accept a level change only after CNT_LAST+1 consecutive mismatching cycles;
  // pulse btn_press when the accepted level becomes "pressed".
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      btn_stable <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      if (sync_btn == btn_stable) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        btn_stable <= sync_btn;
        btn_press  <= sync_btn;
        count      <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/modulo_entrada.sv
// CPU OpIn peripheral: while the CPU holds in_req, waits for an operator
// press and answers with the synchronised switch value and a one-cycle ack.
module modulo_entrada
  import modulo_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int SW_W            = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            button_in,
  input  logic [SW_W-1:0] switches,
  input  logic            in_req,
  output logic            in_ack,
  output logic [31:0]     in_data,
  output logic            waiting
);

  generate
    if (SW_W < 1 || SW_W > 32) begin : g_bad_width
      $error("modulo_entrada: SW_W must be in 1..32");
    end
  endgenerate

  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic            btn_press;
  logic            capture;
  estado_t         state;
  estado_t         state_next;

  debounce_sincrono #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_deb (
    .clock     (clock),
    .reset     (reset),
    .button_in (button_in),
    .btn_press (btn_press)
  );

  // Two-stage synchroniser for the switch bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // Next-state logic; presses outside ARMED are ignored, and a request
  // dropping in the same cycle as a press is treated as an abort.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_req) state_next = ARMED;
      end
      ARMED: begin
        if (!in_req) begin
          state_next = IDLE;
        end else if (btn_press) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = DONE;
      end
      DONE: begin
        if (!in_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered ack and captured data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      in_ack  <= 1'b0;
      in_data <= '0;
    end else begin
      state  <= state_next;
      in_ack <= (state_next == ACK);
      if (capture) in_data <= 32'(sw_sync);
    end
  end

  assign waiting = (state == ARMED);

endmodule

// File: tb/tb_modulo_entrada.sv
// Self-checking bench for modulo_entrada with a short debounce window.
module tb_modulo_entrada;

  localparam int DC   = 4;
  localparam int SW_W = 18;

  logic            clock     = 1'b0;
  logic            reset     = 1'b1;
  logic            button_in = 1'b0;
  logic [SW_W-1:0] switches  = '1;
  logic            in_req    = 1'b0;
  logic            in_ack;
  logic [31:0]     in_data;
  logic            waiting;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int ack_cyc  = -1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [SW_W-1:0] sw;
    logic [31:0]     exp_data;
  } vec_t;
  vec_t vecs[3];

  modulo_entrada #(
    .DEBOUNCE_CYCLES (DC),
    .BTN_ACTIVE_LOW  (1'b1),
    .SW_W            (SW_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button_in (button_in),
    .switches  (switches),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .waiting   (waiting)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match a queued expectation.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (in_ack !== 1'b0) begin
      ack_cnt++;
      ack_cyc = cyc;
      $display("ack cycle=%0d in_data=%h", cyc, in_data);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(in_ack), 32'd0);
      end else begin
        chk("ack_data", in_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_ack(input int start_cnt, input string name);
    int k;
    k = 0;
    while (ack_cnt == start_cnt && k < 30) begin
      step(1);
      k++;
    end
    chk(name, 32'(ack_cnt - start_cnt), 32'd1);
  endtask

  // Press for 10 cycles, release, and wait for the resulting ack.
  task automatic press_and_ack(input string name);
    int a0;
    a0 = ack_cnt;
    button_in = 1'b0;
    step(10);
    button_in = 1'b1;
    wait_ack(a0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int n;
    bit seen_stable;

    vecs[0] = '{sw: 18'h2A5A5, exp_data: 32'h0002A5A5};
    vecs[1] = '{sw: 18'h3FFFF, exp_data: 32'h0003FFFF};
    vecs[2] = '{sw: 18'h00000, exp_data: 32'h00000000};

    // 1: reset with the button held and switches all ones.
    reset = 1'b1; button_in = 1'b0; switches = '1; in_req = 1'b0;
    step(3);
    chk("reset_in_ack",  32'(in_ack),  32'd0);
    chk("reset_in_data", in_data,      32'd0);
    chk("reset_waiting", 32'(waiting), 32'd0);
    reset = 1'b0;
    step(20);
    chk("idle_no_ack", 32'(ack_cnt), 32'd0);
    button_in = 1'b1;
    step(10);

    // 2: table-driven normal transactions with latency check.
    for (int i = 0; i < 3; i++) begin
      switches = vecs[i].sw;
      in_req   = 1'b1;
      step(3);
      chk("waiting_armed", 32'(waiting), 32'd1);
      exp_q.push_back(vecs[i].exp_data);
      a0 = ack_cnt;
      button_in = 1'b0;
      n = cyc + 1;
      step(10);
      button_in = 1'b1;
      wait_ack(a0, "ack_seen");
      chk("ack_latency", 32'(ack_cyc), 32'(n + 6));
      chk("in_data",     in_data, vecs[i].exp_data);
      chk("waiting_after", 32'(waiting), 32'd0);
      in_req = 1'b0;
      step(12);
    end

    // 3: two-cycle glitch while ARMED must not be accepted.
    a0 = ack_cnt;
    in_req = 1'b1;
    step(2);
    button_in = 1'b0;
    step(2);
    button_in = 1'b1;
    seen_stable = 1'b0;
    repeat (12) begin
      step(1);
      if (dut.u_deb.btn_stable !== 1'b0) seen_stable = 1'b1;
    end
    chk("glitch_stable",  32'(seen_stable), 32'd0);
    chk("glitch_waiting", 32'(waiting), 32'd1);
    chk("glitch_no_ack",  32'(ack_cnt - a0), 32'd0);
    in_req = 1'b0;
    step(2);
    chk("glitch_abort_idle", 32'(waiting), 32'd0);

    // 4: button already held when the request arrives.
    button_in = 1'b0;
    step(10);
    switches = 18'h00001;
    in_req   = 1'b1;
    a0 = ack_cnt;
    step(15);
    chk("held_no_ack",  32'(ack_cnt - a0), 32'd0);
    chk("held_waiting", 32'(waiting), 32'd1);
    button_in = 1'b1;
    step(10);
    exp_q.push_back(32'h1);
    press_and_ack("held_fresh_ack");
    chk("held_in_data", in_data, 32'h1);

    // 5: request kept high after the ack; a second press must be ignored.
    a0 = ack_cnt;
    step(8);
    switches  = 18'h12345;
    button_in = 1'b0;
    step(10);
    button_in = 1'b1;
    step(12);
    chk("done_no_second_ack", 32'(ack_cnt - a0), 32'd0);
    chk("done_waiting",       32'(waiting), 32'd0);
    in_req = 1'b0;
    step(2);
    in_req = 1'b1;
    step(2);
    chk("rearm_waiting", 32'(waiting), 32'd1);
    exp_q.push_back(32'h00012345);
    press_and_ack("rearm_ack");
    chk("rearm_in_data", in_data, 32'h00012345);
    in_req = 1'b0;
    step(10);
    // Abort from ARMED keeps the last captured value.
    in_req   = 1'b1;
    switches = 18'h3C3C3;
    step(3);
    chk("abort_armed",   32'(waiting), 32'd1);
    in_req = 1'b0;
    step(2);
    chk("abort_idle",    32'(waiting), 32'd0);
    chk("abort_in_data", in_data, 32'h00012345);

    // 6: reset in the middle of a debounce.
    switches = 18'h0ABCD;
    in_req   = 1'b1;
    step(3);
    a0 = ack_cnt;
    button_in = 1'b0;
    step(4);
    chk("mid_count", 32'(dut.u_deb.count), 32'd2);
    reset = 1'b1; button_in = 1'b1; in_req = 1'b0;
    step(1);
    reset = 1'b0;
    chk("rst_count",   32'(dut.u_deb.count), 32'd0);
    chk("rst_waiting", 32'(waiting), 32'd0);
    chk("rst_in_ack",  32'(in_ack),  32'd0);
    chk("rst_in_data", in_data, 32'd0);
    step(15);
    chk("rst_no_ack", 32'(ack_cnt - a0), 32'd0);
    in_req = 1'b1;
    step(3);
    exp_q.push_back(32'h0000ABCD);
    press_and_ack("post_rst_ack");
    chk("post_rst_in_data", in_data, 32'h0000ABCD);
    in_req = 1'b0;
    step(5);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
